// File: rtl/fir4_inv_if.sv
// -----------------------------------------------------------------------------
// fir4_inv_if -- sample/tap/result bundle for the fir4_inv FIR inverter.
//
// Signals:
//   in_valid   master->slave  y_in carries a sample this cycle
//   in_ready   slave->master  block can accept a sample this cycle
//   y_in       master->slave  signed 16-bit filtered sample
//   h1..h3     master->slave  signed 8-bit taps (h0 is fixed at 1)
//   x_out      slave->master  signed 8-bit recovered sample
//   out_valid  slave->master  one-cycle pulse, x_out is new
//   ovf        slave->master  sticky out-of-range flag
// -----------------------------------------------------------------------------
interface fir4_inv_if;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] y_in;
  logic signed [7:0]  h1;
  logic signed [7:0]  h2;
  logic signed [7:0]  h3;
  logic signed [7:0]  x_out;
  logic               out_valid;
  logic               ovf;

  modport master (
    output in_valid, y_in, h1, h2, h3,
    input  in_ready, x_out, out_valid, ovf
  );

  modport slave (
    input  in_valid, y_in, h1, h2, h3,
    output in_ready, x_out, out_valid, ovf
  );
endinterface

// File: rtl/fir4_inv.sv
// -----------------------------------------------------------------------------
// fir4_inv -- inverse of a monic 4-tap FIR filter.
//
// Computes x[n] = y[n] - h1*x[n-1] - h2*x[n-2] - h3*x[n-3] with a single
// time-shared 8x8 signed multiplier and an 18-bit signed accumulator.
// One sample is processed every 5 cycles (IDLE, MAC1, MAC2, MAC3, DONE).
//
// Ports:
//   clk    rising-edge clock for all state
//   rst_n  asynchronous active-low reset (clears FSM, acc, history, outputs)
//   bus    fir4_inv_if.slave: in_valid/in_ready/y_in, taps h1..h3,
//          x_out/out_valid result and sticky ovf flag
//
// Configuration:
//   FIR4_INV_SAT_EN  defined   -> result clamps to [-128, 127]
//                    undefined -> result is acc[7:0] (two's-complement wrap)
//   ovf is raised identically in both builds.
// -----------------------------------------------------------------------------
module fir4_inv (
  input  logic         clk,
  input  logic         rst_n,
  fir4_inv_if.slave    bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MAC1 = 3'd1,
    MAC2 = 3'd2,
    MAC3 = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t             state_r;
  state_t             state_s;

  logic signed [17:0] acc_r;
  logic signed [17:0] acc_s;

  // history: hist1_r = x[n-1], hist2_r = x[n-2], hist3_r = x[n-3]
  logic signed [7:0]  hist1_r;
  logic signed [7:0]  hist2_r;
  logic signed [7:0]  hist3_r;

  logic signed [7:0]  x_out_r;
  logic               out_valid_r;
  logic               ovf_r;

  logic signed [7:0]  coef_s;
  logic signed [7:0]  data_s;
  logic signed [15:0] prod_s;
  logic signed [17:0] prod_ext_s;
  logic               accept_s;
  logic signed [7:0]  conv_s;
  logic               range_err_s;

  // True when the accumulator does not fit the 8-bit signed result range.
  function automatic logic out_of_range(input logic signed [17:0] a);
    logic r;
    if ((a > 18'sd127) || (a < -18'sd128)) begin
      r = 1'b1;
    end else begin
      r = 1'b0;
    end
    return r;
  endfunction

  // Accumulator to 8-bit result conversion (clamp or wrap by build option).
  function automatic logic signed [7:0] conv(input logic signed [17:0] a);
    logic signed [7:0] r;
`ifdef FIR4_INV_SAT_EN
    if (a > 18'sd127) begin
      r = 8'sh7f;
    end else if (a < -18'sd128) begin
      r = 8'sh80;
    end else begin
      r = a[7:0];
    end
`else
    r = a[7:0];
`endif
    return r;
  endfunction

  assign accept_s    = bus.in_valid && (state_r == IDLE);
  assign prod_s      = coef_s * data_s;
  assign prod_ext_s  = {{2{prod_s[15]}}, prod_s};
  assign conv_s      = conv(acc_r);
  assign range_err_s = out_of_range(acc_r);

  assign bus.in_ready  = (state_r == IDLE);
  assign bus.x_out     = x_out_r;
  assign bus.out_valid = out_valid_r;
  assign bus.ovf       = ovf_r;

  // Multiplier operand select: each MAC state pairs one live tap with its history term.
  always_comb begin
    coef_s = 8'sd0;
    data_s = 8'sd0;
    case (state_r)
      MAC1: begin
        coef_s = bus.h1;
        data_s = hist1_r;
      end
      MAC2: begin
        coef_s = bus.h2;
        data_s = hist2_r;
      end
      MAC3: begin
        coef_s = bus.h3;
        data_s = hist3_r;
      end
      default: begin
        coef_s = 8'sd0;
        data_s = 8'sd0;
      end
    endcase
  end

  // Next-state and accumulator update.
  always_comb begin
    state_s = state_r;
    acc_s   = acc_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = MAC1;
          acc_s   = {{2{bus.y_in[15]}}, bus.y_in};
        end else begin
          state_s = IDLE;
          acc_s   = acc_r;
        end
      end
      MAC1: begin
        state_s = MAC2;
        acc_s   = acc_r - prod_ext_s;
      end
      MAC2: begin
        state_s = MAC3;
        acc_s   = acc_r - prod_ext_s;
      end
      MAC3: begin
        state_s = DONE;
        acc_s   = acc_r - prod_ext_s;
      end
      DONE: begin
        state_s = IDLE;
        acc_s   = acc_r;
      end
      default: begin
        state_s = IDLE;
        acc_s   = 18'sd0;
      end
    endcase
  end

  // FSM state and accumulator registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      acc_r   <= 18'sd0;
    end else begin
      state_r <= state_s;
      acc_r   <= acc_s;
    end
  end

  // Result, history shift, one-cycle valid pulse and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_out_r     <= 8'sd0;
      hist1_r     <= 8'sd0;
      hist2_r     <= 8'sd0;
      hist3_r     <= 8'sd0;
      out_valid_r <= 1'b0;
      ovf_r       <= 1'b0;
    end else if (state_r == DONE) begin
      // history keeps the converted value so the recursion sees what was output
      x_out_r     <= conv_s;
      hist1_r     <= conv_s;
      hist2_r     <= hist1_r;
      hist3_r     <= hist2_r;
      out_valid_r <= 1'b1;
      ovf_r       <= ovf_r | range_err_s;
    end else begin
      out_valid_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fir4_inv.sv
// -----------------------------------------------------------------------------
// tb_fir4_inv -- directed self-checking bench for fir4_inv.
// Inputs are driven on the falling edge, outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_fir4_inv;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  fir4_inv_if bus ();

  fir4_inv dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_taps(input logic signed [7:0] a, input logic signed [7:0] b,
                          input logic signed [7:0] c);
    bus.h1 = a;
    bus.h2 = b;
    bus.h3 = c;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Waits for in_ready, presents one sample for one edge, then counts edges
  // until out_valid; also confirms the pulse is a single cycle wide.
  task automatic do_sample(input logic signed [15:0] y, output logic signed [7:0] x,
                           output int lat);
    int guard;
    @(negedge clk);
    guard = 0;
    while (!bus.in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    tests++;
    if (bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL ready_wait: in_ready=%0b required 1", bus.in_ready);
    end
    bus.y_in     = y;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 10) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    x = bus.x_out;
    @(posedge clk);
    @(negedge clk);
    tests++;
    if (bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL pulse_width: out_valid=%0b required 0 one cycle after result", bus.out_valid);
    end
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.y_in     = 16'sd0;
    set_taps(8'sd0, 8'sd0, 8'sd0);
    repeat (3) @(negedge clk);
    tests++;
    if (bus.x_out !== 8'sd0 || bus.ovf !== 1'b0 || bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs: x_out=%0d ovf=%0b out_valid=%0b required 0 0 0",
               bus.x_out, bus.ovf, bus.out_valid);
    end
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready: in_ready=%0b required 1", bus.in_ready);
    end
  endtask

  task automatic test_inverse();
    logic signed [15:0] ys [5];
    logic signed [7:0]  xs [5];
    logic signed [7:0]  x;
    int lat;
    // taps 2,3,4: 5; 16-10; 34-12-15; 60-14-18-20; 61-16-21-24
    ys = '{16'sd5, 16'sd16, 16'sd34, 16'sd60, 16'sd61};
    xs = '{8'sd5, 8'sd6, 8'sd7, 8'sd8, 8'sd0};
    pulse_reset();
    set_taps(8'sd2, 8'sd3, 8'sd4);
    for (int i = 0; i < 5; i++) begin
      do_sample(ys[i], x, lat);
      tests++;
      if (x !== xs[i] || lat != 4) begin
        fails++;
        $display("FAIL inverse[%0d]: x_out=%0d lat=%0d required %0d lat=4", i, x, lat, xs[i]);
      end
    end
    tests++;
    if (bus.ovf !== 1'b0) begin
      fails++;
      $display("FAIL inverse_ovf: ovf=%0b required 0", bus.ovf);
    end
  endtask

  task automatic test_recursion();
    logic signed [7:0] x;
    int lat;
    // h1 = -1 turns the inverse into x[n] = 1 + x[n-1]: 1,2,3,...
    pulse_reset();
    set_taps(-8'sd1, 8'sd0, 8'sd0);
    for (int i = 0; i < 6; i++) begin
      do_sample(16'sd1, x, lat);
      tests++;
      if (x !== 8'(i + 1) || lat != 4) begin
        fails++;
        $display("FAIL recursion[%0d]: x_out=%0d lat=%0d required %0d lat=4", i, x, lat, i + 1);
      end
    end
    tests++;
    if (bus.ovf !== 1'b0) begin
      fails++;
      $display("FAIL recursion_ovf: ovf=%0b required 0", bus.ovf);
    end
  endtask

  task automatic test_back_to_back();
    int accepts;
    int pulses;
    logic exp_ready;
    logic exp_pulse;
    set_taps(8'sd0, 8'sd0, 8'sd0);
    bus.y_in = 16'sd5;
    @(negedge clk);
    accepts = 0;
    pulses  = 0;
    for (int i = 0; i < 30; i++) begin
      bus.in_valid = (i < 25);
      exp_ready = (i <= 25) ? ((i % 5) == 0) : 1'b1;
      exp_pulse = (i > 0) && (i <= 25) && ((i % 5) == 0);
      tests++;
      if (bus.in_ready !== exp_ready || bus.out_valid !== exp_pulse) begin
        fails++;
        $display("FAIL b2b_cycle[%0d]: in_ready=%0b out_valid=%0b required %0b %0b",
                 i, bus.in_ready, bus.out_valid, exp_ready, exp_pulse);
      end
      if (bus.in_valid && bus.in_ready) accepts++;
      if (bus.out_valid) pulses++;
      @(posedge clk);
      @(negedge clk);
    end
    tests++;
    if (accepts != 5 || pulses != 5 || bus.x_out !== 8'sd5) begin
      fails++;
      $display("FAIL b2b_totals: accepts=%0d pulses=%0d x_out=%0d required 5 5 5",
               accepts, pulses, bus.x_out);
    end
  endtask

  task automatic test_ovf();
    logic signed [7:0] x;
    logic signed [7:0] exp_big;
    int lat;
`ifdef FIR4_INV_SAT_EN
    exp_big = 8'sd127;
`else
    exp_big = 8'sd44;
`endif
    set_taps(8'sd0, 8'sd0, 8'sd0);
    do_sample(-16'sd100, x, lat);
    tests++;
    if (x !== -8'sd100 || bus.ovf !== 1'b0) begin
      fails++;
      $display("FAIL ovf_neg100: x_out=%0d ovf=%0b required -100 0", x, bus.ovf);
    end
    do_sample(16'sd300, x, lat);
    tests++;
    if (x !== exp_big || bus.ovf !== 1'b1) begin
      fails++;
      $display("FAIL ovf_300: x_out=%0d ovf=%0b required %0d 1", x, bus.ovf, exp_big);
    end
    // stays set across a later in-range result
    do_sample(16'sd3, x, lat);
    tests++;
    if (x !== 8'sd3 || bus.ovf !== 1'b1) begin
      fails++;
      $display("FAIL ovf_sticky: x_out=%0d ovf=%0b required 3 1", x, bus.ovf);
    end
  endtask

  task automatic test_mid_reset();
    logic signed [7:0] x;
    int lat;
    int seen;
    pulse_reset();
    set_taps(8'sd2, 8'sd3, 8'sd4);
    do_sample(16'sd5, x, lat);   // history now holds 5
    @(negedge clk);
    bus.y_in     = 16'sd5;
    bus.in_valid = 1'b1;
    @(posedge clk);              // accepted -> MAC1
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);              // -> MAC2
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    tests++;
    if (bus.x_out !== 8'sd0 || bus.out_valid !== 1'b0 || bus.ovf !== 1'b0) begin
      fails++;
      $display("FAIL midreset_outputs: x_out=%0d out_valid=%0b ovf=%0b required 0 0 0",
               bus.x_out, bus.out_valid, bus.ovf);
    end
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    tests++;
    if (seen != 0 || bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL midreset_abort: pulses=%0d in_ready=%0b required 0 1", seen, bus.in_ready);
    end
    do_sample(16'sd16, x, lat);
    tests++;
    if (x !== 8'sd16 || lat != 4) begin
      fails++;
      $display("FAIL midreset_history: x_out=%0d lat=%0d required 16 lat=4", x, lat);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_inverse();
    test_recursion();
    test_back_to_back();
    test_ovf();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
